// File: rtl/proc_pkg.sv
// ============================================================================
// Module : proc_pkg
// Brief  : Shared register-file widths, link register index and data types.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;
  localparam int DATA_WIDTH    = 16;
  localparam int REG_ADDR_BITS = 3;
  localparam int LINK_REG      = 7;

  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;
endpackage

`default_nettype wire

// File: rtl/scoreboard_bits.sv
// ============================================================================
// Module : scoreboard_bits
// Brief  : Per-register pending-write bits with set-over-clear priority and
//          a registered population count of the pending vector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scoreboard_bits
  import proc_pkg::*;
#(
  parameter int RegAddrBits = REG_ADDR_BITS,
  parameter int TotalReg    = 2**RegAddrBits,
  parameter int ZeroReg     = 1,
  parameter int LinkReg     = LINK_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_iss_en,
  input  logic [RegAddrBits-1:0] i_iss_dest,
  input  logic                   i_wr_en,
  input  logic [RegAddrBits-1:0] i_wr_addr,
  input  logic                   i_link_en,
  output logic [TotalReg-1:0]    o_pending,
  output logic [RegAddrBits:0]   o_pend_cnt
);

  localparam logic [RegAddrBits-1:0] c_link_addr = RegAddrBits'(LinkReg);

  logic [TotalReg-1:0]  r_pending;
  logic [TotalReg-1:0]  w_pend_next;
  logic [RegAddrBits:0] r_pend_cnt;
  logic [RegAddrBits:0] w_cnt_next;
  logic                 w_iss_ok;

  assign w_iss_ok = i_iss_en && !((ZeroReg != 0) && (i_iss_dest == '0));

  // Set is applied last so a newly issued producer beats a retiring one.
  always_comb begin
    w_pend_next = r_pending;
    if (i_wr_en)   w_pend_next[i_wr_addr]   = 1'b0;
    if (i_link_en) w_pend_next[c_link_addr] = 1'b0;
    if (w_iss_ok)  w_pend_next[i_iss_dest]  = 1'b1;
  end

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < TotalReg; i++) begin
      w_cnt_next = w_cnt_next + (RegAddrBits+1)'(w_pend_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending  <= w_pend_next;
      r_pend_cnt <= w_cnt_next;
    end
  end

  assign o_pending  = r_pending;
  assign o_pend_cnt = r_pend_cnt;

endmodule

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// Module : reg_file_scoreboard
// Brief  : Two-read/one-write register file with link write, debug port and
//          hazard scoreboard. Define REGFILE_BYPASS_EN for writeback forwarding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
  import proc_pkg::*;
#(
  parameter int DataWidth   = DATA_WIDTH,
  parameter int RegAddrBits = REG_ADDR_BITS,
  parameter int ZeroReg     = 1,
  parameter int LinkReg     = LINK_REG
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [RegAddrBits-1:0] rd_addr_a,
  input  logic [RegAddrBits-1:0] rd_addr_b,
  output logic [DataWidth-1:0]   rd_data_a,
  output logic [DataWidth-1:0]   rd_data_b,
  input  logic                   wr_en,
  input  logic [RegAddrBits-1:0] wr_addr,
  input  logic [DataWidth-1:0]   wr_data,
  input  logic                   link_en,
  input  logic [DataWidth-1:0]   link_data,
  input  logic                   iss_en,
  input  logic [RegAddrBits-1:0] iss_dest,
  output logic                   stall,
  input  logic [RegAddrBits-1:0] inr,
  output logic [DataWidth-1:0]   out_value,
  output logic [RegAddrBits:0]   pend_cnt
);

  localparam int                     TotalReg    = 2**RegAddrBits;
  localparam logic [RegAddrBits-1:0] c_link_addr = RegAddrBits'(LinkReg);

  logic [DataWidth-1:0]   r_regs [TotalReg];
  logic [DataWidth-1:0]   r_out_value;
  logic [TotalReg-1:0]    w_pending;
  logic                   w_wr_ok;
  logic                   w_link_ok;
  logic [RegAddrBits-1:0] w_rd_addr [2];
  logic [DataWidth-1:0]   w_rd_data [2];
  logic [1:0]             w_port_stall;

  assign w_wr_ok   = wr_en   && !((ZeroReg != 0) && (wr_addr == '0));
  assign w_link_ok = link_en && !((ZeroReg != 0) && (c_link_addr == '0));

  // Link write is issued after writeback so it wins a same-register collision.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TotalReg; i++) r_regs[i] <= '0;
      r_out_value <= '0;
    end else begin
      r_out_value <= r_regs[inr];
      if (w_wr_ok)   r_regs[wr_addr]     <= wr_data;
      if (w_link_ok) r_regs[c_link_addr] <= link_data;
    end
  end

  scoreboard_bits #(
    .RegAddrBits (RegAddrBits),
    .TotalReg    (TotalReg),
    .ZeroReg     (ZeroReg),
    .LinkReg     (LinkReg)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (RST),
    .i_iss_en   (iss_en),
    .i_iss_dest (iss_dest),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_link_en  (link_en),
    .o_pending  (w_pending),
    .o_pend_cnt (pend_cnt)
  );

  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      logic w_zero;
      logic w_byp_link;
      logic w_byp_wr;

      assign w_zero = (ZeroReg != 0) && (w_rd_addr[p] == '0);
`ifdef REGFILE_BYPASS_EN
      assign w_byp_link = link_en && (w_rd_addr[p] == c_link_addr) && !w_zero;
      assign w_byp_wr   = wr_en && (wr_addr == w_rd_addr[p]) && !w_zero;
`else
      assign w_byp_link = 1'b0;
      assign w_byp_wr   = 1'b0;
`endif

      always_comb begin
        w_rd_data[p] = r_regs[w_rd_addr[p]];
        if (w_zero)          w_rd_data[p] = '0;
        else if (w_byp_link) w_rd_data[p] = link_data;
        else if (w_byp_wr)   w_rd_data[p] = wr_data;
      end

      // A forwarded operand is already available, so it cannot hold decode.
      assign w_port_stall[p] = w_pending[w_rd_addr[p]] && !w_zero
                               && !(w_byp_link || w_byp_wr);
    end
  endgenerate

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];
  assign stall     = |w_port_stall;
  assign out_value = r_out_value;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
// ============================================================================
// Module : tb_reg_file_scoreboard
// Brief  : Directed and random checks of reg_file_scoreboard against a
//          behavioural model; honours REGFILE_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_scoreboard;
  import proc_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  logic      CLK;
  logic      RST;
  reg_addr_t rd_addr_a, rd_addr_b, wr_addr, iss_dest, inr;
  data_t     rd_data_a, rd_data_b, wr_data, link_data, out_value;
  logic      wr_en, link_en, iss_en, stall;
  logic [3:0] pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  data_t m_regs [8];
  bit    m_pend [8];

  reg_file_scoreboard dut (
    .CLK       (CLK),
    .RST       (RST),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .link_en   (link_en),
    .link_data (link_data),
    .iss_en    (iss_en),
    .iss_dest  (iss_dest),
    .stall     (stall),
    .inr       (inr),
    .out_value (out_value),
    .pend_cnt  (pend_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bool_bypassed(input reg_addr_t a);
    return c_byp && ((link_en && a == 3'd7) || (wr_en && wr_addr == a));
  endfunction

  function automatic data_t exp_rd(input reg_addr_t a);
    if (a == 3'd0) return 16'h0;
    if (c_byp && link_en && a == 3'd7) return link_data;
    if (c_byp && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_port_stall(input reg_addr_t a);
    if (a == 3'd0) return 1'b0;
    if (bool_bypassed(a)) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    wr_en = 0; link_en = 0; iss_en = 0;
    wr_addr = 0; wr_data = 0; link_data = 0; iss_dest = 0;
  endtask

  // One clock: check combinational outputs, clock, apply rules, check registers.
  task automatic step();
    data_t exp_out;
    #1;
    chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
    chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
    chk("stall", stall, exp_port_stall(rd_addr_a) || exp_port_stall(rd_addr_b));
    exp_out = m_regs[inr];
    @(posedge CLK);
    if (wr_en && wr_addr != 3'd0) m_regs[wr_addr] = wr_data;
    if (link_en) m_regs[7] = link_data;
    if (wr_en) m_pend[wr_addr] = 1'b0;
    if (link_en) m_pend[7] = 1'b0;
    if (iss_en && iss_dest != 3'd0) m_pend[iss_dest] = 1'b1;
    #1;
    chk("out_value", out_value, exp_out);
    chk("pend_cnt", pend_cnt, m_count());
  endtask

  initial begin
    RST = 1'b1;
    idle();
    rd_addr_a = 0; rd_addr_b = 0; inr = 0;
    model_reset();
    #2;
    chk("rst_rd_a", rd_data_a, 16'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pend_cnt", pend_cnt, 4'd0);
    chk("rst_out_value", out_value, 16'h0);
    #8 RST = 1'b0;
    @(posedge CLK); #1;

    // Debug scan after reset
    for (int i = 0; i < 8; i++) begin
      inr = reg_addr_t'(i);
      rd_addr_a = reg_addr_t'(i);
      rd_addr_b = reg_addr_t'(7 - i);
      step();
      chk("scan_out", out_value, 16'h0);
    end

    // Zero register ignores writes and issues
    wr_en = 1; wr_addr = 0; wr_data = 16'h1234;
    iss_en = 1; iss_dest = 0; rd_addr_a = 0;
    step();
    idle();
    #1;
    chk("zero_rd", rd_data_a, 16'h0);
    chk("zero_pend", pend_cnt, 4'd0);
    step();

    // RAW hazard on r2
    iss_en = 1; iss_dest = 2; rd_addr_a = 2; rd_addr_b = 0;
    step();
    idle();
    step();
    step();
    wr_en = 1; wr_addr = 2; wr_data = 16'h0003;
    #1;
    chk("raw_wb_stall", stall, !c_byp);
    step();
    idle();
    #1;
    chk("raw_stall_clear", stall, 1'b0);
    chk("raw_rd", rd_data_a, 16'h0003);
    step();

    // Set/clear collision on r4
    iss_en = 1; iss_dest = 4; wr_en = 1; wr_addr = 4; wr_data = 16'h00AA;
    step();
    idle();
    rd_addr_b = 4;
    #1;
    chk("coll_rd", rd_data_b, 16'h00AA);
    chk("coll_stall", stall, 1'b1);
    chk("coll_pend", pend_cnt, 4'd1);
    step();

    // Link wins over writeback on r7
    rd_addr_b = 0;
    iss_en = 1; iss_dest = 7;
    step();
    idle();
    wr_en = 1; wr_addr = 7; wr_data = 16'h1111;
    link_en = 1; link_data = 16'h000D; inr = 7;
    step();
    idle();
    step();
    chk("link_out", out_value, 16'h000D);
    chk("link_pend", pend_cnt, 4'd1);

    // Three pending (r4 retires as r1 issues), then async reset between edges
    iss_en = 1; iss_dest = 1; wr_en = 1; wr_addr = 4; wr_data = 16'h0055;
    step();
    idle(); iss_en = 1; iss_dest = 3;
    step();
    idle(); iss_en = 1; iss_dest = 5;
    step();
    idle();
    chk("pre_rst_pend", pend_cnt, 4'd3);
    rd_addr_a = 1; rd_addr_b = 3;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    RST = 1'b1;
    #1;
    model_reset();
    chk("arst_pend", pend_cnt, 4'd0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_out", out_value, 16'h0);
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = reg_addr_t'(i);
      rd_addr_b = reg_addr_t'(i + 4);
      #1;
      chk("arst_rd_a", rd_data_a, 16'h0);
      chk("arst_rd_b", rd_data_b, 16'h0);
    end
    RST = 1'b0;
    @(posedge CLK); #1;

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      rd_addr_a = reg_addr_t'($urandom_range(0, 7));
      rd_addr_b = reg_addr_t'($urandom_range(0, 7));
      inr       = reg_addr_t'($urandom_range(0, 7));
      wr_en     = ($urandom_range(0, 9) < 4);
      wr_addr   = reg_addr_t'($urandom_range(0, 7));
      wr_data   = data_t'($urandom);
      link_en   = ($urandom_range(0, 9) < 2);
      link_data = data_t'($urandom);
      iss_en    = ($urandom_range(0, 9) < 4);
      iss_dest  = reg_addr_t'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
